dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MEM stage and data memory.
- Unlike the load-use hazard logic, which consumes ID-stage register information and freezes the front end, this block is the originator of a pipeline-wide memory stall. It asserts cpu_stall_o on a miss and holds it until the line is resident.
- Talks to data memory over a single-outstanding enable/ack line-transfer handshake.

Parameters:
SETS, 16, number of cache lines; index width = log2(SETS) = 4.
LINE_W, 256, line width in bits (32 bytes, 8 words).
TAG_W, 23, tag width = 32 - 4 (index) - 5 (offset).

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-high reset.
cpu_req_i  input  1  MEM stage issues a load or store this cycle.
cpu_write_i  input  1  1 = store, 0 = load; valid with cpu_req_i.
cpu_addr_i  input  32  byte address; [4:2] word select, [8:5] index, [31:9] tag, [1:0] ignored.
cpu_data_i  input  32  store data.
cpu_data_o  output  32  load data; valid when cpu_req_i=1 and cpu_stall_o=0.
cpu_stall_o  output  1  freeze whole pipeline.
mem_enable_o  output  1  memory request, held until ack.
mem_write_o  output  1  1 = line writeback, 0 = line fill.
mem_addr_o  output  32  line-aligned address, [4:0]=0.
mem_data_o  output  256  writeback line.
mem_data_i  input  256  fill line; valid in the mem_ack_i cycle.
mem_ack_i  input  1  one-cycle completion pulse.

Behaviour:
- Storage per set: valid, dirty, tag, line. Read is asynchronous; write happens on the clock edge.
- hit = cpu_req_i & valid[idx] & (tag[idx]==addr tag).
- cpu_stall_o = cpu_req_i & ~hit, or state != IDLE. It is combinational, asserted in the same cycle a miss is presented.
- Read hit: cpu_data_o = selected word, same cycle, zero stall. With no request, cpu_data_o = 0.
- Write hit: the selected word is replaced at the clock edge and dirty[idx] is set to 1.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
  - IDLE, miss, victim valid&dirty -> WRITEBACK.
  - IDLE, miss, otherwise -> REFILL.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, idx, 5'b0}, mem_data_o=victim line. On mem_ack_i -> REFILL.
  - REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, idx, 5'b0}. On mem_ack_i, the line is written from mem_data_i with tag updated, valid=1, dirty=0 -> DONE.
  - DONE: stall still 1, for one cycle -> IDLE. The request is then a hit, and stall drops that cycle.
- Memory outputs are registered and change only on state entry. mem_enable_o stays high continuously through WRITEBACK->REFILL; mem_write_o drops on the REFILL entry.
- A store miss fills the line first. The store then completes as a write hit in IDLE and sets dirty.
- mem_ack_i is ignored in IDLE and DONE.
- The CPU must hold cpu_req_i, cpu_write_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1. If cpu_req_i drops mid-miss, the fill still completes.
- Latency: clean miss = memory latency + 2 cycles; dirty miss adds one more memory latency.
- Reset (any time, including mid-transfer):
  - state=IDLE; all valid and dirty bits = 0.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - The outstanding memory transaction is abandoned; a late ack is ignored.
  - Tag and data arrays need not reset.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum {IDLE, WRITEBACK, REFILL, DONE};
  - OFFSET_W=5, INDEX_W=4, TAG_W=23, LINE_W=256;
  - address-field slice helpers.
- One sub-module, dcache_sram: the tag/valid/dirty/data arrays. It has async read, a synchronous write port with a word-write/line-write select, and async clear of valid/dirty on rst_i.

Test Plan:
- Reset, then load 0x0000_0104 (memory ack after 3 cycles) -> stall rises same cycle; REFILL request addr 0x0000_0100, no WRITEBACK; stall drops 5 cycles after request; cpu_data_o = word 1 of the fill line.
- Store 0xDEADBEEF to 0x0000_0108 after the above -> no stall; immediate load of 0x108 returns 0xDEADBEEF; dirty[8]=1.
- Load 0x0000_0300 (same index 8, new tag) -> WRITEBACK to 0x0000_0100 with mem_data_o containing 0xDEADBEEF at word 2, then REFILL 0x0000_0300; dirty[8]=0 afterwards.
- Store miss to 0x0000_0040 -> refill 0x0000_0040, then word 0 written, dirty[2]=1, stall total = latency+2.
- Assert rst_i during REFILL, then send a stray mem_ack_i -> all outputs 0, state IDLE; the ack is ignored; the next load to the same address misses again.
- mem_ack_i pulsed while IDLE with hits ongoing -> no state change, hits unaffected.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM state type and address-field helpers for the data cache
package dcache_pkg;
  localparam int OFFSET_W = 5;
  localparam int INDEX_W = 4;
  localparam int TAG_W = 23;
  localparam int LINE_W = 256;
  localparam int SETS = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:OFFSET_W+INDEX_W];
  endfunction
  function automatic logic [INDEX_W-1:0] addr_idx(input logic [31:0] a);
    return a[OFFSET_W+INDEX_W-1:OFFSET_W];
  endfunction
  function automatic logic [2:0] addr_word(input logic [31:0] a);
    return a[OFFSET_W-1:2];
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data arrays of the direct-mapped cache
//   clk_i, rst_i          clock, async active-high clear of valid/dirty
//   idx                   set addressed by both the read and the write port
//   word_we/word_sel/word_data   store one word, marks the set dirty
//   line_we/line_tag/line_data   install a whole line, valid and clean
//   rd_valid/rd_dirty/rd_tag/rd_line   asynchronous read of set idx
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [INDEX_W-1:0] idx,
  input  logic              word_we,
  input  logic [2:0]        word_sel,
  input  logic [31:0]       word_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line
);
  logic [SETS-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [SETS];
  logic [LINE_W-1:0] lines [SETS];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag = tags[idx];
  assign rd_line = lines[idx];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we)
      dirty[idx] <= 1'b1;
  // tag and data storage carry no reset; valid gates their use
  always_ff @(posedge clk_i)
    if (line_we) begin
      tags[idx] <= line_tag;
      lines[idx] <= line_data;
    end else if (word_we)
      lines[idx][{word_sel, 5'b0} +: 32] <= word_data;
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache with line-transfer memory port
//   clk_i, rst_i              clock, async active-high reset
//   cpu_req_i/cpu_write_i/cpu_addr_i/cpu_data_i   MEM-stage load/store request
//   cpu_data_o, cpu_stall_o   load data, pipeline-wide stall on miss
//   mem_enable_o/mem_write_o/mem_addr_o/mem_data_o   registered line request (writeback or fill)
//   mem_data_i, mem_ack_i     fill line and one-cycle completion pulse
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  state_t state, state_d;
  logic [TAG_W+INDEX_W-1:0] miss_line, miss_line_d;
  logic mem_enable_d, mem_write_d;
  logic [31:0] mem_addr_d;
  logic [LINE_W-1:0] mem_data_d;
  logic [INDEX_W-1:0] idx;
  logic rd_valid, rd_dirty, hit, victim_dirty, word_we, line_we;
  logic [TAG_W-1:0] rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic unused_ok;
  assign unused_ok = ^cpu_addr_i[1:0];
  // outside IDLE the arrays follow the latched miss line, so a dropped request cannot redirect the fill
  assign idx = (state == IDLE) ? addr_idx(cpu_addr_i) : miss_line[INDEX_W-1:0];
  assign hit = cpu_req_i & rd_valid & (rd_tag == addr_tag(cpu_addr_i));
  assign victim_dirty = rd_valid & rd_dirty;
  assign cpu_stall_o = (cpu_req_i & ~hit) | (state != IDLE);
  assign cpu_data_o = cpu_req_i ? rd_line[{addr_word(cpu_addr_i), 5'b0} +: 32] : 32'h0;
  // a store miss completes here too, as a hit once the fill is resident
  assign word_we = (state == IDLE) & cpu_req_i & cpu_write_i & hit;
  assign line_we = (state == REFILL) & mem_ack_i;
  dcache_sram u_sram (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .idx(idx),
    .word_we(word_we),
    .word_sel(addr_word(cpu_addr_i)),
    .word_data(cpu_data_i),
    .line_we(line_we),
    .line_tag(miss_line[TAG_W+INDEX_W-1:INDEX_W]),
    .line_data(mem_data_i),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag(rd_tag),
    .rd_line(rd_line)
  );
  // memory outputs are computed as next values and registered, so they only move on state entry
  always_comb begin
    state_d = state;
    miss_line_d = miss_line;
    mem_enable_d = mem_enable_o;
    mem_write_d = mem_write_o;
    mem_addr_d = mem_addr_o;
    mem_data_d = mem_data_o;
    case (state)
      IDLE:
        if (cpu_req_i & ~hit) begin
          state_d = victim_dirty ? WRITEBACK : REFILL;
          miss_line_d = {addr_tag(cpu_addr_i), addr_idx(cpu_addr_i)};
          mem_enable_d = 1'b1;
          mem_write_d = victim_dirty;
          mem_addr_d = victim_dirty ? {rd_tag, addr_idx(cpu_addr_i), 5'b0}
                                    : {addr_tag(cpu_addr_i), addr_idx(cpu_addr_i), 5'b0};
          mem_data_d = victim_dirty ? rd_line : mem_data_o;
        end
      WRITEBACK:
        if (mem_ack_i) begin
          state_d = REFILL;
          mem_write_d = 1'b0;
          mem_addr_d = {miss_line, 5'b0};
        end
      REFILL:
        if (mem_ack_i) begin
          state_d = DONE;
          mem_enable_d = 1'b0;
        end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      miss_line <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      state <= state_d;
      miss_line <= miss_line_d;
      mem_enable_o <= mem_enable_d;
      mem_write_o <= mem_write_d;
      mem_addr_o <= mem_addr_d;
      mem_data_o <= mem_data_d;
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed self-checking bench for the data cache controller
module tb_dcache_controller;
  import dcache_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i, cpu_req_i, cpu_write_i, cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o, mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r = 0;
  always #5 clk_i = ~clk_i;
  dcache_controller dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cpu_req_i(cpu_req_i),
    .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(negedge clk_i);
    cyc++;
  endtask
  function automatic logic [255:0] mk_line(input logic [31:0] b);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = b + 32'(w);
    return l;
  endfunction
  // waits (bounded) for the expected request, checks its address, then acks in its lat-th cycle
  task automatic serve(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [255:0] fill, input int lat);
    int k = 0;
    while (!(mem_enable_o && mem_write_o == wr) && k < 20) begin
      step;
      k++;
    end
    check({tag, " request"}, {mem_enable_o, mem_write_o}, {1'b1, wr});
    check({tag, " addr"}, mem_addr_o, addr);
    for (int i = 1; i < lat; i++) step;
    mem_data_i = fill;
    mem_ack_i = 1'b1;
    step;
    mem_ack_i = 1'b0;
  endtask
  task automatic wait_stall_low;
    int k = 0;
    while (cpu_stall_o && k < 20) begin
      step;
      #1;
      k++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    cpu_write_i = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    mem_data_i = '0;
    mem_ack_i = 1'b0;
    step;
    step;
    #1;
    check("reset mem outputs", {mem_enable_o, mem_write_o, mem_addr_o}, '0);
    check("reset mem data", mem_data_o, '0);
    check("reset cpu outputs", {cpu_stall_o, cpu_data_o}, '0);
    check("reset state", dut.state, IDLE);
    rst_i = 1'b0;
    // clean load miss, latency 3
    step;
    cpu_req_i = 1'b1;
    cpu_addr_i = 32'h104;
    r = cyc;
    #1;
    check("t1 stall same cycle", cpu_stall_o, 1'b1);
    serve("t1 refill", 1'b0, 32'h100, mk_line(32'h1000_0000), 3);
    wait_stall_low;
    check("t1 stall cycles", cyc - r, 5);
    check("t1 load data", cpu_data_o, 32'h1000_0001);
    // store hit then load back
    step;
    cpu_write_i = 1'b1;
    cpu_addr_i = 32'h108;
    cpu_data_i = 32'hDEADBEEF;
    #1;
    check("t2 store hit stall", cpu_stall_o, 1'b0);
    step;
    cpu_write_i = 1'b0;
    #1;
    check("t2 load back", cpu_data_o, 32'hDEADBEEF);
    check("t2 load stall", cpu_stall_o, 1'b0);
    check("t2 dirty8", dut.u_sram.dirty[8], 1'b1);
    // conflicting load forces writeback of the dirty line
    step;
    cpu_addr_i = 32'h300;
    r = cyc;
    #1;
    check("t3 stall", cpu_stall_o, 1'b1);
    step;
    #1;
    check("t3 wb word2", mem_data_o[95:64], 32'hDEADBEEF);
    check("t3 wb word1", mem_data_o[63:32], 32'h1000_0001);
    serve("t3 writeback", 1'b1, 32'h100, '0, 2);
    check("t3 enable held", mem_enable_o, 1'b1);
    serve("t3 refill", 1'b0, 32'h300, mk_line(32'h3000_0000), 2);
    wait_stall_low;
    check("t3 stall cycles", cyc - r, 6);
    check("t3 load data", cpu_data_o, 32'h3000_0000);
    check("t3 dirty8", dut.u_sram.dirty[8], 1'b0);
    // store miss allocates, then completes as a hit
    step;
    cpu_write_i = 1'b1;
    cpu_addr_i = 32'h40;
    cpu_data_i = 32'hCAFEF00D;
    r = cyc;
    #1;
    check("t4 stall", cpu_stall_o, 1'b1);
    serve("t4 refill", 1'b0, 32'h40, mk_line(32'h4000_0000), 3);
    wait_stall_low;
    check("t4 stall cycles", cyc - r, 5);
    step;
    cpu_write_i = 1'b0;
    #1;
    check("t4 load stored", cpu_data_o, 32'hCAFEF00D);
    check("t4 dirty2", dut.u_sram.dirty[2], 1'b1);
    cpu_addr_i = 32'h44;
    #1;
    check("t4 fill word1", cpu_data_o, 32'h4000_0001);
    // reset during refill, then a stray ack
    step;
    cpu_addr_i = 32'h480;
    #1;
    check("t5 stall", cpu_stall_o, 1'b1);
    step;
    #1;
    check("t5 refill started", {mem_enable_o, mem_write_o}, 2'b10);
    cpu_req_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("t5 reset mem outputs", {mem_enable_o, mem_write_o, mem_addr_o}, '0);
    check("t5 reset mem data", mem_data_o, '0);
    check("t5 reset state", dut.state, IDLE);
    check("t5 reset stall", cpu_stall_o, 1'b0);
    check("t5 reset dirty2", dut.u_sram.dirty[2], 1'b0);
    step;
    rst_i = 1'b0;
    step;
    mem_data_i = mk_line(32'h5000_0000);
    mem_ack_i = 1'b1;
    step;
    mem_ack_i = 1'b0;
    #1;
    check("t5 stray ack enable", mem_enable_o, 1'b0);
    check("t5 stray ack state", dut.state, IDLE);
    cpu_req_i = 1'b1;
    cpu_addr_i = 32'h480;
    r = cyc;
    #1;
    check("t5 re-miss", cpu_stall_o, 1'b1);
    serve("t5 refill", 1'b0, 32'h480, mk_line(32'h4800_0000), 1);
    wait_stall_low;
    check("t5 stall cycles", cyc - r, 3);
    check("t5 load data", cpu_data_o, 32'h4800_0000);
    // ack pulses in IDLE while hits continue
    step;
    cpu_addr_i = 32'h484;
    mem_data_i = '1;
    mem_ack_i = 1'b1;
    #1;
    check("t6 hit stall", cpu_stall_o, 1'b0);
    check("t6 hit data", cpu_data_o, 32'h4800_0001);
    step;
    cpu_addr_i = 32'h488;
    #1;
    check("t6 hit2 data", {cpu_stall_o, cpu_data_o}, {1'b0, 32'h4800_0002});
    check("t6 idle held", {mem_enable_o, dut.state}, {1'b0, IDLE});
    mem_ack_i = 1'b0;
    step;
    #1;
    check("t6 line intact", cpu_data_o, 32'h4800_0002);
    cpu_req_i = 1'b0;
    #1;
    check("no request data", cpu_data_o, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
